// File: rtl/mem_arbiter_nch.sv
// N-channel byte-serial arbiter onto the shared 8-bit RAM/IO bus.
// Bus pins, done pulse and read data are registered; a byte appears on the bus the cycle after its issue edge.
module mem_arbiter_nch #(
    parameter int unsigned NUM_CH   = 3,
    parameter int unsigned ARB_MODE = 0,
    parameter int unsigned CH_W     = 2
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   rdy_in,
    input  logic                   clear,
    input  logic [NUM_CH-1:0]      ch_valid,
    input  logic [NUM_CH-1:0]      ch_wr,
    input  logic [3*NUM_CH-1:0]    ch_len,
    input  logic [32*NUM_CH-1:0]   ch_addr,
    input  logic [32*NUM_CH-1:0]   ch_wdata,
    input  logic [NUM_CH-1:0]      ch_flushable,
    output logic [NUM_CH-1:0]      ch_done,
    output logic [31:0]            rdata,
    output logic                   busy,
    output logic [CH_W-1:0]        grant_idx,
    input  logic [7:0]             mem_din,
    output logic [7:0]             mem_dout,
    output logic [31:0]            mem_a,
    output logic                   mem_wr,
    input  logic                   io_buffer_full
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LEN_W  = 3;
    localparam int unsigned K_W    = 2;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [K_W-1:0]      k_q, issue_k_q, cap_k_q;
    logic [CH_W-1:0]     rr_ptr_q, win_idx_c;
    logic [ADDR_W-1:0]   addr_q, sel_addr_c, cur_addr_c;
    logic [LEN_W-1:0]    len_q, sel_len_c;
    logic [DATA_W-1:0]   wdata_q, sel_wdata_c;
    logic                wr_q, flush_q, kill_q, issue_q, cap_q;
    logic                sel_wr_c, sel_flush_c;
    logic [NUM_CH-1:0]   cand_c;
    logic                win_found_c, latch_c, io_addr_c, io_stall_c, last_byte_c;
    logic                in_xfer_c, abort_c, io_kill_c, issue_c;
    logic [NUM_CH-1:0]   ch_done_d;
    logic [ADDR_W-1:0]   mem_a_d;
    logic [BYTE_W-1:0]   mem_dout_d;
    logic                mem_wr_d, busy_d, issue_d;

    // Speculative reads are not eligible while the pipeline is being cleared.
    assign cand_c = ch_valid & ~({NUM_CH{clear}} & ch_flushable & ~ch_wr);

    // Winner select: later loop iterations override, so they carry the higher priority.
    always_comb begin
        win_found_c = 1'b0;
        win_idx_c   = '0;
        if (ARB_MODE == 0) begin
            for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
                if (cand_c[i]) begin
                    win_found_c = 1'b1;
                    win_idx_c   = CH_W'(i);
                end
            end
        end else begin
            for (int j = int'(NUM_CH); j >= 1; j--) begin
                for (int c = 0; c < int'(NUM_CH); c++) begin
                    if (cand_c[c] && (32'(c) == (32'(rr_ptr_q) + 32'(j)) % NUM_CH)) begin
                        win_found_c = 1'b1;
                        win_idx_c   = CH_W'(c);
                    end
                end
            end
        end
    end

    always_comb begin
        sel_addr_c  = '0;
        sel_wdata_c = '0;
        sel_len_c   = '0;
        sel_wr_c    = 1'b0;
        sel_flush_c = 1'b0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (CH_W'(i) == win_idx_c) begin
                sel_addr_c  = ch_addr[32*i +: 32];
                sel_wdata_c = ch_wdata[32*i +: 32];
                sel_len_c   = ch_len[3*i +: 3];
                sel_wr_c    = ch_wr[i];
                sel_flush_c = ch_flushable[i];
            end
        end
    end

    always_comb begin
        cur_addr_c  = addr_q + ADDR_W'(k_q);
        io_addr_c   = (addr_q[17:16] == 2'b11);
        io_stall_c  = wr_q && (cur_addr_c[17:16] == 2'b11) && io_buffer_full;
        last_byte_c = (k_q == K_W'(len_q - LEN_W'(1)));
        in_xfer_c   = (state_q == XFER) || (state_q == DRAIN);
        abort_c     = rdy_in && clear && in_xfer_c && flush_q && !wr_q && !io_addr_c;
        io_kill_c   = rdy_in && clear && in_xfer_c && flush_q && !wr_q && io_addr_c;
        // Hold off arbitration while a done pulse is out so the requester can drop valid.
        latch_c     = rdy_in && (state_q == IDLE) && win_found_c && (ch_done == '0);
        issue_c     = rdy_in && (state_q == XFER) && !abort_c && !io_stall_c;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (latch_c) state_d = XFER;
            end
            XFER: begin
                if (abort_c) begin
                    state_d = IDLE;
                end else if (issue_c && last_byte_c) begin
                    state_d = wr_q ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if (abort_c) begin
                    state_d = IDLE;
                end else if (rdy_in) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (rdy_in) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ch_done_d  = '0;
        mem_a_d    = '0;
        mem_wr_d   = 1'b0;
        mem_dout_d = '0;
        issue_d    = 1'b0;
        busy_d     = (state_d != IDLE);
        if (issue_c) begin
            mem_a_d    = cur_addr_c;
            mem_wr_d   = wr_q;
            mem_dout_d = wdata_q[{k_q, 3'b000} +: 8];
            issue_d    = !wr_q;
        end
        if (rdy_in && (state_q == DONE) && !kill_q) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (CH_W'(i) == grant_idx) ch_done_d[i] = 1'b1;
            end
        end
    end

    // Output registers, latched request and the two-stage read-return pipeline.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            ch_done   <= '0;
            rdata     <= '0;
            busy      <= 1'b0;
            grant_idx <= '0;
            mem_a     <= '0;
            mem_dout  <= '0;
            mem_wr    <= 1'b0;
            rr_ptr_q  <= CH_W'(NUM_CH - 1);
            k_q       <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            wdata_q   <= '0;
            wr_q      <= 1'b0;
            flush_q   <= 1'b0;
            kill_q    <= 1'b0;
            issue_q   <= 1'b0;
            issue_k_q <= '0;
            cap_q     <= 1'b0;
            cap_k_q   <= '0;
        end else begin
            ch_done   <= ch_done_d;
            busy      <= busy_d;
            mem_a     <= mem_a_d;
            mem_wr    <= mem_wr_d;
            mem_dout  <= mem_dout_d;
            issue_q   <= issue_d;
            issue_k_q <= k_q;
            cap_q     <= issue_q && !abort_c;
            cap_k_q   <= issue_k_q;
            if (cap_q) rdata[{cap_k_q, 3'b000} +: 8] <= mem_din;
            if (issue_c && !last_byte_c) k_q <= k_q + K_W'(1);
            if (io_kill_c) kill_q <= 1'b1;
            if (latch_c) begin
                grant_idx <= win_idx_c;
                addr_q    <= sel_addr_c;
                len_q     <= sel_len_c;
                wdata_q   <= sel_wdata_c;
                wr_q      <= sel_wr_c;
                flush_q   <= sel_flush_c;
                kill_q    <= 1'b0;
                k_q       <= '0;
                rdata     <= '0;
                if (ARB_MODE != 0) rr_ptr_q <= win_idx_c;
            end
        end
    end

endmodule
